dvi_serdes_ctrl: RTL and testbench
==================================

# dvi_serdes_ctrl

Sequencer and 10:5 gearbox in front of the four DVI output serializers (three TMDS data lanes plus clock lane). Takes 10-bit TMDS symbols from the encoders and splits them into 5-bit halves, LSB half first, at the serializer parallel clock, which runs at 2x pixel rate. Owns the serializer reset after PLL lock, flushes the lanes with blanking tokens, and then streams pixel symbols with a ready/valid handshake.

## Interface
- RST_CYCLES, 16: gclk cycles that serdes_rst is held after lock is seen; range 2..255.
- FLUSH_CYCLES, 32: gclk cycles of control-token output after serdes_rst release; even, range 2..1024.
- gclk  in  1  serializer parallel clock (2x pixel clock); the only clock.
- reset_n  in  1  asynchronous active-low reset.
- pll_locked  in  1  PLL/MMCM lock; asynchronous, synchronized internally.
- sym_data  in  30  {lane2, lane1, lane0} 10-bit TMDS symbols; bit 0 of each symbol is transmitted first.
- sym_valid  in  1  sym_data is valid.
- sym_ready  out  1  block takes sym_data on this edge if sym_valid is high.
- serdes_rst  out  1  reset to all four serializers; active-high.
- lane_data  out  20  {clk lane, lane2, lane1, lane0} 5-bit halves to the serializer datain ports.
- running  out  1  high in RUN state.
- underrun  out  1  sticky flag: a symbol slot passed with no valid data.
- underrun_clr  in  1  single-cycle clear of underrun.

## Operation
- The block uses a 2-FF synchronizer on pll_locked; lock_s is the synchronized value.
- FSM states:
  - WAIT_LOCK (reset state): serdes_rst=1. When lock_s=1, go to RST_HOLD and clear the counter.
  - RST_HOLD: serdes_rst=1 for RST_CYCLES cycles, then go to FLUSH. serdes_rst=0 from the first FLUSH cycle.
  - FLUSH: output the token stream for FLUSH_CYCLES cycles, then go to RUN. The exit happens only at ph=1, so RUN starts at ph=0.
  - RUN: running=1. Stream symbols.
- lock_s=0 in any state: the next state is WAIT_LOCK, serdes_rst=1, ph=0, lane_data=TOK_LO, and the counter is cleared. This takes priority over all other transitions.
- Phase bit ph toggles every cycle in every state. It is forced to 0 in WAIT_LOCK.
- Constants:
  - Control token for C=00 is 10'b1101010100. TOK_LO=5'b10100, TOK_HI=5'b11010.
  - Clock lane symbol is 10'b1111100000. CLK_LO=5'b00000, CLK_HI=5'b11111.
- Gearbox, on an edge with ph=0:
  - The hold register loads sym_data if in RUN and sym_valid=1. Otherwise it loads the token on all three lanes.
  - lane_data is loaded with {CLK_LO, low halves[4:0]}.
- Gearbox, on an edge with ph=1: lane_data is loaded with {CLK_HI, hold high halves[9:5]}.
- sym_ready = running & ~ph. It is a registered-state decode with no combinational path from sym_valid.
- In WAIT_LOCK, RST_HOLD and FLUSH, data lanes carry tokens and the clock lane carries the clock pattern, phase-aligned.
- underrun:
  - Set on a ph=0 edge in RUN with sym_valid=0.
  - Cleared by underrun_clr.
  - Set wins over a simultaneous clear.
  - Not set outside RUN.
- The counter is wide enough for max(RST_CYCLES, FLUSH_CYCLES) and saturates, with no wrap.

## Timing
- All outputs are registered except sym_ready, which is a decode of registers.
- Reset values: serdes_rst=1, lane_data={CLK_LO, TOK_LO×3}=20'h0_5294, running=0, underrun=0, sym_ready=0, ph=0.
- Lock rise to RST_HOLD entry is 2 sync cycles plus 1.
- serdes_rst deasserts exactly RST_CYCLES cycles after RST_HOLD entry.
- running rises FLUSH_CYCLES (or +1 to align ph) cycles after serdes_rst falls.
- Symbol accepted at edge N: its low half is on lane_data after edge N and its high half after edge N+1.
- Throughput is one symbol per 2 gclk cycles.
- Lock loss mid-symbol: any pending high half is discarded, and lane_data=TOK_LO on the cycle after lock_s falls.
- Asynchronous reset mid-operation restores all reset values immediately.

## Test plan
- Reset/lock-up sequence:
  - Stimulus: hold reset_n low, then raise it with pll_locked=0; later set pll_locked=1.
  - Required: serdes_rst=1 and lane_data=20'h05294 throughout the first phase. serdes_rst falls exactly 16 cycles after RST_HOLD entry (default parameters). running rises after 32 FLUSH cycles, at ph=0.
- Gearbox ordering:
  - Stimulus: in RUN, send lane0=10'h3FF, lane1=10'h000, lane2=10'h2AA with sym_valid held high.
  - Required: low-half cycle {00000, 01010, 00000, 11111}, then high-half cycle {11111, 10101, 00000, 11111}. sym_ready toggles 1/0.
- Underrun:
  - Stimulus: drop sym_valid for one ph=0 slot.
  - Required: that slot carries the token halves 10100 then 11010 on all data lanes. underrun=1 and stays set. An underrun_clr pulse clears it; a clear coincident with a new underrun leaves it 1.
- Lock loss in RUN:
  - Stimulus: drop pll_locked after a low half has been output.
  - Required: 2 cycles later the FSM is in WAIT_LOCK, serdes_rst=1, running=0, sym_ready=0, lane_data=TOK_LO. Re-lock repeats the full sequence.
- Back-pressure:
  - Stimulus: hold sym_valid=1 constantly with an incrementing data pattern.
  - Required: exactly one symbol is accepted per 2 cycles with none dropped or duplicated (scoreboard over 1000 symbols).
- Parameter corner:
  - Stimulus: set RST_CYCLES=2 and FLUSH_CYCLES=2.
  - Required: the sequence completes and RUN starts at ph=0.

Source files
------------

// File: rtl/dvi_serdes_ctrl.sv
// dvi_serdes_ctrl: serializer reset/flush sequencer and 10:5 TMDS gearbox.
// Emits LSB-first 5-bit halves of three data symbols plus the clock lane at 2x pixel rate.
module dvi_serdes_ctrl #(
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned FLUSH_CYCLES = 32
) (
    input  logic        gclk,
    input  logic        reset_n,
    input  logic        pll_locked,
    input  logic [29:0] sym_data,
    input  logic        sym_valid,
    output logic        sym_ready,
    output logic        serdes_rst,
    output logic [19:0] lane_data,
    output logic        running,
    output logic        underrun,
    input  logic        underrun_clr
);
    localparam int unsigned HALF_W  = 5;
    localparam int unsigned SYM_W   = 10;
    localparam int unsigned CNT_MAX = (RST_CYCLES > FLUSH_CYCLES) ? RST_CYCLES : FLUSH_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [SYM_W-1:0]  TOKEN  = 10'b1101010100;
    localparam logic [HALF_W-1:0] TOK_LO = 5'b10100;
    localparam logic [HALF_W-1:0] TOK_HI = 5'b11010;
    localparam logic [HALF_W-1:0] CLK_LO = 5'b00000;
    localparam logic [HALF_W-1:0] CLK_HI = 5'b11111;
    localparam logic [19:0]       LANE_IDLE = {CLK_LO, TOK_LO, TOK_LO, TOK_LO};

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_RST_HOLD  = 2'd1,
        S_FLUSH     = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_lock_meta;
    logic               r_lock_s;
    logic               r_ph;
    logic               r_serdes_rst;
    logic               r_running;
    logic               r_underrun;
    logic [19:0]        r_lane;
    logic [14:0]        r_hold;
    logic [29:0]        w_sym_sel;
    logic [14:0]        w_lo;
    logic [14:0]        w_hi;
    logic               w_ur_set;

    // Two-flop synchronizer for the asynchronous lock indication.
    always_ff @(posedge gclk or negedge reset_n) begin
        if (!reset_n) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= pll_locked;
            r_lock_s    <= r_lock_meta;
        end
    end

    always_ff @(posedge gclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_WAIT_LOCK;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Counter saturates rather than wraps; FLUSH only exits on ph=1 so RUN opens on ph=0.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = (r_cnt == CNT_W'(CNT_MAX)) ? r_cnt : r_cnt + CNT_W'(1);
        case (r_state)
            S_WAIT_LOCK: begin
                w_cnt_nxt = '0;
                if (r_lock_s) begin
                    w_state_nxt = S_RST_HOLD;
                end
            end
            S_RST_HOLD: begin
                if (r_cnt >= CNT_W'(RST_CYCLES - 1)) begin
                    w_state_nxt = S_FLUSH;
                    w_cnt_nxt   = '0;
                end
            end
            S_FLUSH: begin
                if ((r_cnt >= CNT_W'(FLUSH_CYCLES - 1)) && r_ph) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end
            end
            S_RUN: begin
                w_cnt_nxt = '0;
            end
            default: begin
                w_state_nxt = S_WAIT_LOCK;
                w_cnt_nxt   = '0;
            end
        endcase
        if (!r_lock_s) begin
            w_state_nxt = S_WAIT_LOCK;
            w_cnt_nxt   = '0;
        end
    end

    assign w_sym_sel = ((r_state == S_RUN) && sym_valid) ? sym_data : {3{TOKEN}};
    assign w_lo      = {w_sym_sel[24:20], w_sym_sel[14:10], w_sym_sel[4:0]};
    assign w_hi      = {w_sym_sel[29:25], w_sym_sel[19:15], w_sym_sel[9:5]};
    assign w_ur_set  = (r_state == S_RUN) && !r_ph && !sym_valid;

    always_ff @(posedge gclk or negedge reset_n) begin
        if (!reset_n) begin
            r_ph         <= 1'b0;
            r_serdes_rst <= 1'b1;
            r_running    <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_ph         <= (w_state_nxt == S_WAIT_LOCK) ? 1'b0 : ~r_ph;
            r_serdes_rst <= !((w_state_nxt == S_FLUSH) || (w_state_nxt == S_RUN));
            r_running    <= (w_state_nxt == S_RUN);
            if (w_ur_set) begin
                r_underrun <= 1'b1;
            end else if (underrun_clr) begin
                r_underrun <= 1'b0;
            end
        end
    end

    // Gearbox: ph=0 captures a symbol (or tokens) and sends low halves; ph=1 sends held high halves.
    always_ff @(posedge gclk or negedge reset_n) begin
        if (!reset_n) begin
            r_lane <= LANE_IDLE;
            r_hold <= {TOK_HI, TOK_HI, TOK_HI};
        end else if (!r_lock_s) begin
            r_lane <= LANE_IDLE;
            r_hold <= {TOK_HI, TOK_HI, TOK_HI};
        end else if (!r_ph) begin
            r_lane <= {CLK_LO, w_lo};
            r_hold <= w_hi;
        end else begin
            r_lane <= {CLK_HI, r_hold};
        end
    end

    assign sym_ready  = r_running & ~r_ph;
    assign serdes_rst = r_serdes_rst;
    assign running    = r_running;
    assign underrun   = r_underrun;
    assign lane_data  = r_lane;

endmodule

// File: tb/tb_dvi_serdes_ctrl.sv
// Directed bench for dvi_serdes_ctrl: lock-up sequencing, gearbox vectors, underrun,
// lock loss, back-pressure scoreboard and a minimum-parameter instance.
module tb_dvi_serdes_ctrl;
    localparam logic [19:0] LANE_TOK_LO = 20'h05294;
    localparam logic [19:0] LANE_TOK_HI = 20'hFEB5A;

    logic        gclk;
    logic        reset_n;
    logic        pll_locked;
    logic [29:0] sym_data;
    logic        sym_valid;
    logic        underrun_clr;
    logic        sym_ready;
    logic        serdes_rst;
    logic [19:0] lane_data;
    logic        running;
    logic        underrun;

    logic        sym_ready2;
    logic        serdes_rst2;
    logic [19:0] lane_data2;
    logic        running2;
    logic        underrun2;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic        valid;
        logic [29:0] data;
        logic [19:0] exp_lo;
        logic [19:0] exp_hi;
        logic        exp_ur;
    } vec_t;

    vec_t vec[4];

    dvi_serdes_ctrl dut (
        .gclk         (gclk),
        .reset_n      (reset_n),
        .pll_locked   (pll_locked),
        .sym_data     (sym_data),
        .sym_valid    (sym_valid),
        .sym_ready    (sym_ready),
        .serdes_rst   (serdes_rst),
        .lane_data    (lane_data),
        .running      (running),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    dvi_serdes_ctrl #(.RST_CYCLES(2), .FLUSH_CYCLES(2)) dut_min (
        .gclk         (gclk),
        .reset_n      (reset_n),
        .pll_locked   (pll_locked),
        .sym_data     (30'h0),
        .sym_valid    (1'b1),
        .sym_ready    (sym_ready2),
        .serdes_rst   (serdes_rst2),
        .lane_data    (lane_data2),
        .running      (running2),
        .underrun     (underrun2),
        .underrun_clr (1'b0)
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge gclk);
        #1;
    endtask

    // Raise lock and time both instances through RST_HOLD and FLUSH into RUN.
    task automatic do_lockup();
        pll_locked = 1'b1;
        fork
            begin
                int n;
                logic [19:0] exp_lane;
                n = 0;
                do begin
                    step();
                    n++;
                end while (serdes_rst && n < 100);
                chk("rst_hold_len", 32'(n), 32'd19);
                chk("flush_first_lane", 32'(lane_data), 32'(LANE_TOK_LO));
                n = 0;
                while (!running && n < 100) begin
                    step();
                    n++;
                    exp_lane = n[0] ? LANE_TOK_HI : LANE_TOK_LO;
                    chk("flush_lane", 32'(lane_data), 32'(exp_lane));
                end
                chk("flush_len", 32'(n), 32'd33);
                chk("run_start_ph0", 32'(sym_ready), 32'd1);
            end
            begin
                int m;
                m = 0;
                do begin
                    step();
                    m++;
                end while (serdes_rst2 && m < 100);
                chk("min_rst_hold_len", 32'(m), 32'd5);
                m = 0;
                while (!running2 && m < 100) begin
                    step();
                    m++;
                end
                chk("min_flush_len", 32'(m), 32'd3);
                chk("min_run_start_ph0", 32'(sym_ready2), 32'd1);
            end
        join
    endtask

    task automatic send_vec(input vec_t v);
        chk("slot_ready", 32'(sym_ready), 32'd1);
        sym_valid = v.valid;
        sym_data  = v.data;
        step();
        chk("lane_lo", 32'(lane_data), 32'(v.exp_lo));
        chk("ready_lo", 32'(sym_ready), 32'd0);
        chk("underrun_vec", 32'(underrun), 32'(v.exp_ur));
        step();
        chk("lane_hi", 32'(lane_data), 32'(v.exp_hi));
    endtask

    initial begin
        logic [29:0] q[$];
        logic [14:0] lo_h;
        logic        have_lo;
        logic [29:0] rebuilt;
        logic [29:0] exp_sym;
        int          pushed;
        int          matched;
        int          n;

        vec[0] = '{1'b1, {10'h2AA, 10'h000, 10'h3FF}, 20'h0281F, 20'hFD41F, 1'b0};
        vec[1] = '{1'b1, {10'h000, 10'h3FF, 10'h000}, 20'h003E0, 20'hF83E0, 1'b0};
        vec[2] = '{1'b0, 30'h3FFFFFFF,                20'h05294, 20'hFEB5A, 1'b1};
        vec[3] = '{1'b1, {10'h155, 10'h0F0, 10'h30F}, 20'h0560F, 20'hFA8F8, 1'b1};

        n_cmp = 0;
        n_bad = 0;
        reset_n      = 1'b0;
        pll_locked   = 1'b0;
        sym_valid    = 1'b0;
        sym_data     = '0;
        underrun_clr = 1'b0;

        #12;
        chk("rst_serdes_rst", 32'(serdes_rst), 32'd1);
        chk("rst_lane", 32'(lane_data), 32'(LANE_TOK_LO));
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_ready", 32'(sym_ready), 32'd0);
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("wait_serdes_rst", 32'(serdes_rst), 32'd1);
            chk("wait_lane", 32'(lane_data), 32'(LANE_TOK_LO));
        end

        do_lockup();

        for (int i = 0; i < 4; i++) begin
            send_vec(vec[i]);
        end

        // Clear alone, then clear coincident with a fresh underrun slot.
        sym_valid    = 1'b1;
        sym_data     = 30'h1;
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        chk("underrun_clear", 32'(underrun), 32'd0);
        step();
        sym_valid    = 1'b0;
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        chk("underrun_set_wins", 32'(underrun), 32'd1);
        step();
        chk("underrun_sticky", 32'(underrun), 32'd1);

        // Back-pressure: constant valid, scoreboard rebuilds each symbol from its two halves.
        sym_valid = 1'b1;
        have_lo   = 1'b0;
        pushed    = 0;
        matched   = 0;
        for (int k = 0; k <= 2000; k++) begin
            if (lane_data[19:15] == 5'b00000) begin
                lo_h    = lane_data[14:0];
                have_lo = (q.size() > 0);
            end else if (have_lo && q.size() > 0) begin
                rebuilt = {lane_data[14:10], lo_h[14:10], lane_data[9:5], lo_h[9:5],
                           lane_data[4:0], lo_h[4:0]};
                exp_sym = q.pop_front();
                chk("bp_symbol", 32'(rebuilt), 32'(exp_sym));
                matched++;
                have_lo = 1'b0;
            end
            if (sym_ready && pushed < 1000) begin
                sym_data = {10'(pushed * 3), 10'(pushed * 7 + 1), 10'(pushed)};
                q.push_back(sym_data);
                pushed++;
            end
            step();
        end
        chk("bp_matched", 32'(matched), 32'd1000);
        chk("bp_pushed", 32'(pushed), 32'd1000);
        chk("bp_queue_empty", 32'(q.size()), 32'd0);

        // A low half is on the lanes now; drop lock mid-symbol.
        chk("lockloss_lo_half", 32'(lane_data[19:15]), 32'd0);
        pll_locked = 1'b0;
        n = 0;
        while (running && n < 10) begin
            step();
            n++;
        end
        chk("lockloss_latency", 32'(n >= 2 && n <= 3), 32'd1);
        chk("lockloss_serdes_rst", 32'(serdes_rst), 32'd1);
        chk("lockloss_running", 32'(running), 32'd0);
        chk("lockloss_ready", 32'(sym_ready), 32'd0);
        chk("lockloss_lane", 32'(lane_data), 32'(LANE_TOK_LO));
        step();
        chk("lockloss_lane_hold", 32'(lane_data), 32'(LANE_TOK_LO));
        chk("min_lockloss_rst", 32'(serdes_rst2), 32'd1);
        step();

        do_lockup();
        send_vec(vec[3]);

        // Asynchronous reset mid-run takes effect without a clock edge.
        sym_valid = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset_serdes_rst", 32'(serdes_rst), 32'd1);
        chk("areset_lane", 32'(lane_data), 32'(LANE_TOK_LO));
        chk("areset_running", 32'(running), 32'd0);
        chk("areset_underrun", 32'(underrun), 32'd0);
        chk("areset_ready", 32'(sym_ready), 32'd0);
        chk("areset_min_running", 32'(running2), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
